// File: rtl/cache_bus_arbiter_if.sv
// One cache-refill/writeback bus: request, write-beat and read-beat channels.
// The cache side drives through the master modport; the arbiter serves it through slave.
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [LEN_W-1:0]      len;
  logic                  wvalid;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  wready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  rlast;

  modport master (
    output req_valid, we, addr, len, wvalid, wdata, wstrb, wlast,
    input  req_ready, wready, rvalid, rdata, rlast
  );

  modport slave (
    input  req_valid, we, addr, len, wvalid, wdata, wstrb, wlast,
    output req_ready, wready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the icache (m0) and dcache (m1).
// Grants whole bursts, routes beats to the owner, and flags burst-length mismatches.
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  cache_bus_arbiter_if.slave  m0,
  cache_bus_arbiter_if.slave  m1,
  cache_bus_arbiter_if.master s,
  output logic                owner_o,
  output logic                busy_o,
  output logic                len_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA, WDATA} state_t;

  state_t              state, state_nx;
  logic                owner, prio, len_err;
  logic [LEN_W-1:0]    beat_cnt, len_q;

  logic                grant_fire, grant_idx, req_fire, beat_fire, beat_last, xfer_done;

  // Owner-side view of the two requesters.
  logic                sel_req_valid, sel_we, sel_wvalid, sel_wlast;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;

  assign sel_req_valid = owner ? m1.req_valid : m0.req_valid;
  assign sel_we        = owner ? m1.we        : m0.we;
  assign sel_addr      = owner ? m1.addr      : m0.addr;
  assign sel_len       = owner ? m1.len       : m0.len;
  assign sel_wvalid    = owner ? m1.wvalid    : m0.wvalid;
  assign sel_wdata     = owner ? m1.wdata     : m0.wdata;
  assign sel_wstrb     = owner ? m1.wstrb     : m0.wstrb;
  assign sel_wlast     = owner ? m1.wlast     : m0.wlast;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx     = state;
    grant_fire   = 1'b0;
    grant_idx    = 1'b0;
    req_fire     = 1'b0;
    beat_fire    = 1'b0;
    beat_last    = 1'b0;
    s.req_valid  = 1'b0;
    s.we         = 1'b0;
    s.addr       = '0;
    s.len        = '0;
    s.wvalid     = 1'b0;
    s.wdata      = '0;
    s.wstrb      = '0;
    s.wlast      = 1'b0;
    m0.req_ready = 1'b0;
    m0.wready    = 1'b0;
    m0.rvalid    = 1'b0;
    m0.rdata     = '0;
    m0.rlast     = 1'b0;
    m1.req_ready = 1'b0;
    m1.wready    = 1'b0;
    m1.rvalid    = 1'b0;
    m1.rdata     = '0;
    m1.rlast     = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0.req_valid || m1.req_valid) begin
          grant_fire = 1'b1;
          grant_idx  = (m0.req_valid && m1.req_valid) ? prio : m1.req_valid;
          state_nx   = REQ;
        end
      end

      REQ: begin
        s.req_valid = sel_req_valid;
        s.we        = sel_we;
        s.addr      = sel_addr;
        s.len       = sel_len;
        if (owner) m1.req_ready = s.req_ready;
        else       m0.req_ready = s.req_ready;
        // A requester that withdraws before acceptance forfeits the grant without a priority turn.
        if (!sel_req_valid) begin
          state_nx = IDLE;
        end else if (s.req_ready) begin
          req_fire = 1'b1;
          state_nx = sel_we ? WDATA : RDATA;
        end
      end

      RDATA: begin
        if (owner) begin
          m1.rvalid = s.rvalid;
          m1.rdata  = s.rdata;
          m1.rlast  = s.rlast;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rdata  = s.rdata;
          m0.rlast  = s.rlast;
        end
        beat_fire = s.rvalid;
        beat_last = s.rlast;
        if (s.rvalid && s.rlast) state_nx = IDLE;
      end

      WDATA: begin
        s.wvalid = sel_wvalid;
        s.wdata  = sel_wdata;
        s.wstrb  = sel_wstrb;
        s.wlast  = sel_wlast;
        if (owner) m1.wready = s.wready;
        else       m0.wready = s.wready;
        beat_fire = sel_wvalid && s.wready;
        beat_last = sel_wlast;
        if (beat_fire && sel_wlast) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

  assign xfer_done = beat_fire && beat_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      prio     <= 1'b0;
      beat_cnt <= '0;
      len_q    <= '0;
      len_err  <= 1'b0;
    end else begin
      if (grant_fire) owner <= grant_idx;
      if (req_fire) begin
        len_q    <= sel_len;
        beat_cnt <= '0;
      end else if (beat_fire && beat_cnt != '1) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      // beat_cnt is the index of the current beat: last must land exactly on len.
      if (beat_fire && (beat_last ? (beat_cnt != len_q) : (beat_cnt == len_q))) len_err <= 1'b1;
      if (xfer_done) prio <= ~owner;
    end
  end

  assign busy_o    = (state != IDLE);
  assign owner_o   = owner;
  assign len_err_o = len_err;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed and randomized bench for cache_bus_arbiter; a round-robin model predicts
// the winner of each burst and the sticky length-error flag.
module tb_cache_bus_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic owner_o, busy_o, len_err_o;

  always #5 clk = ~clk;

  cache_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m0_bus ();
  cache_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) m1_bus ();
  cache_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) s_bus ();

  cache_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .owner_o   (owner_o),
    .busy_o    (busy_o),
    .len_err_o (len_err_o)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: port that wins a tie, and whether a length violation has been seen.
  bit exp_prio = 1'b0;
  bit exp_err  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus.req_valid = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.len = '0;
    m0_bus.wvalid = 1'b0; m0_bus.wdata = '0; m0_bus.wstrb = '0; m0_bus.wlast = 1'b0;
    m1_bus.req_valid = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.len = '0;
    m1_bus.wvalid = 1'b0; m1_bus.wdata = '0; m1_bus.wstrb = '0; m1_bus.wlast = 1'b0;
    s_bus.req_ready = 1'b0; s_bus.wready = 1'b0;
    s_bus.rvalid = 1'b0; s_bus.rdata = '0; s_bus.rlast = 1'b0;
  endtask

  task automatic set_req(input bit p, input bit v, input bit we, input logic [31:0] a,
                         input logic [7:0] len);
    if (p) begin
      m1_bus.req_valid = v; m1_bus.we = we; m1_bus.addr = a; m1_bus.len = len;
    end else begin
      m0_bus.req_valid = v; m0_bus.we = we; m0_bus.addr = a; m0_bus.len = len;
    end
  endtask

  task automatic set_w(input bit p, input bit v, input logic [31:0] d, input logic [3:0] st,
                       input bit last);
    if (p) begin
      m1_bus.wvalid = v; m1_bus.wdata = d; m1_bus.wstrb = st; m1_bus.wlast = last;
    end else begin
      m0_bus.wvalid = v; m0_bus.wdata = d; m0_bus.wstrb = st; m0_bus.wlast = last;
    end
  endtask

  function automatic logic get_req_ready(input bit p);
    return p ? m1_bus.req_ready : m0_bus.req_ready;
  endfunction
  function automatic logic get_wready(input bit p);
    return p ? m1_bus.wready : m0_bus.wready;
  endfunction
  function automatic logic get_rvalid(input bit p);
    return p ? m1_bus.rvalid : m0_bus.rvalid;
  endfunction
  function automatic logic [31:0] get_rdata(input bit p);
    return p ? m1_bus.rdata : m0_bus.rdata;
  endfunction
  function automatic logic get_rlast(input bit p);
    return p ? m1_bus.rlast : m0_bus.rlast;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    exp_prio = 1'b0;
    exp_err  = 1'b0;
  endtask

  // One whole burst starting from IDLE. v0/v1 select which ports request; the model
  // picks the winner. rst_at >= 0 asserts reset during that read beat instead of finishing.
  task automatic arb_round(input bit v0, input bit v1, input bit we, input logic [7:0] len,
                           input int nbeats, input bit keep, input bit wrand,
                           input int rst_at, input logic [31:0] a0_in);
    logic [31:0] a0, a1, d;
    logic [3:0]  st;
    bit          w, last, rv, wr;
    int          b, guard;
    a0 = (a0_in != 0) ? a0_in : $urandom;
    a1 = $urandom;
    if (v0) set_req(1'b0, 1'b1, we, a0, len);
    if (v1) set_req(1'b1, 1'b1, we, a1, len);
    w = (v0 && v1) ? exp_prio : v1;

    #1;
    check("idle_no_comb_grant", s_bus.req_valid, 0);
    check("idle_busy", busy_o, 0);
    tick();
    check("grant_owner", owner_o, w);
    check("grant_busy", busy_o, 1);
    check("req_fwd_valid", s_bus.req_valid, 1);
    check("req_fwd_addr", s_bus.addr, w ? a1 : a0);
    check("req_fwd_len", s_bus.len, len);
    check("req_fwd_we", s_bus.we, we);
    s_bus.req_ready = 1'b1;
    #1;
    check("req_ready_owner", get_req_ready(w), 1);
    check("req_ready_other", get_req_ready(!w), 0);
    tick();
    s_bus.req_ready = 1'b0;
    if (!keep) set_req(w, 1'b0, we, w ? a1 : a0, len);

    b = 0;
    guard = 0;
    d  = $urandom;
    st = 4'($urandom);
    while (b < nbeats) begin
      last = (b == nbeats - 1);
      guard++;
      if (guard > 64 * nbeats) begin
        check("beat_timeout", 64'(b), 64'(nbeats));
        break;
      end
      if (!we) begin
        rv = (rst_at >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        d  = $urandom;
        s_bus.rvalid = rv; s_bus.rdata = d; s_bus.rlast = last;
        if (rst_at == b) begin
          rst = 1'b1;
          #1;
          check("rst_busy", busy_o, 0);
          check("rst_owner", owner_o, 0);
          check("rst_len_err", len_err_o, 0);
          check("rst_rvalid0", get_rvalid(1'b0), 0);
          check("rst_rvalid1", get_rvalid(1'b1), 0);
          check("rst_s_req_valid", s_bus.req_valid, 0);
          tick();
          check("rst_held_rvalid", get_rvalid(w), 0);
          check("rst_held_busy", busy_o, 0);
          rst = 1'b0;
          clear_inputs();
          exp_prio = 1'b0;
          exp_err  = 1'b0;
          return;
        end
        #1;
        check("rd_rvalid_owner", get_rvalid(w), rv);
        check("rd_rvalid_other", get_rvalid(!w), 0);
        if (rv) begin
          check("rd_rdata", get_rdata(w), d);
          check("rd_rlast", get_rlast(w), last);
        end
        check("rd_len_err", len_err_o, exp_err);
        check("rd_owner", owner_o, w);
        tick();
        if (rv) begin
          if (last ? (b != int'(len)) : (b == int'(len))) exp_err = 1'b1;
          b++;
        end
      end else begin
        set_w(w, 1'b1, d, st, last);
        set_w(!w, 1'b1, ~d, ~st, 1'b0);
        wr = wrand ? ($urandom_range(0, 3) != 0) : (guard % 2 == 1);
        s_bus.wready = wr;
        #1;
        check("wr_s_wvalid", s_bus.wvalid, 1);
        check("wr_s_wdata", s_bus.wdata, d);
        check("wr_s_wstrb", s_bus.wstrb, st);
        check("wr_s_wlast", s_bus.wlast, last);
        check("wr_wready_owner", get_wready(w), wr);
        check("wr_wready_other", get_wready(!w), 0);
        check("wr_len_err", len_err_o, exp_err);
        tick();
        if (wr) begin
          if (last ? (b != int'(len)) : (b == int'(len))) exp_err = 1'b1;
          b++;
          d  = $urandom;
          st = 4'($urandom);
        end
      end
    end

    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; s_bus.wready = 1'b0;
    set_w(1'b0, 1'b0, '0, '0, 1'b0);
    set_w(1'b1, 1'b0, '0, '0, 1'b0);
    exp_prio = !w;
    #1;
    check("done_busy", busy_o, 0);
    check("done_len_err", len_err_o, exp_err);
  endtask

  // Requester withdraws while the downstream bus has not yet accepted.
  task automatic req_drop(input bit p);
    set_req(p, 1'b1, 1'b0, $urandom, 8'd2);
    s_bus.req_ready = 1'b0;
    #1;
    check("drop_idle_no_fwd", s_bus.req_valid, 0);
    tick();
    check("drop_busy_req", busy_o, 1);
    check("drop_owner", owner_o, p);
    check("drop_fwd_valid", s_bus.req_valid, 1);
    check("drop_req_ready", get_req_ready(p), 0);
    set_req(p, 1'b0, 1'b0, '0, '0);
    #1;
    check("drop_fwd_cleared", s_bus.req_valid, 0);
    tick();
    check("drop_back_idle", busy_o, 0);
    check("drop_s_req_valid", s_bus.req_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy_o, 0);
    check("reset_owner", owner_o, 0);
    check("reset_len_err", len_err_o, 0);
    check("reset_s_req_valid", s_bus.req_valid, 0);
    check("reset_m0_req_ready", m0_bus.req_ready, 0);
    check("reset_m1_rvalid", m1_bus.rvalid, 0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_stays", busy_o, 0);

    // Single icache read burst.
    arb_round(1'b1, 1'b0, 1'b0, 8'd3, 4, 1'b0, 1'b1, -1, 32'h1C00_0000);

    // Contention straight after reset, then alternating grants with both held.
    do_reset();
    arb_round(1'b1, 1'b1, 1'b0, 8'd0, 1, 1'b0, 1'b1, -1, 32'h0);
    arb_round(1'b0, 1'b1, 1'b0, 8'd0, 1, 1'b0, 1'b1, -1, 32'h0);
    for (int i = 0; i < 4; i++) arb_round(1'b1, 1'b1, 1'b0, 8'd0, 1, 1'b1, 1'b1, -1, 32'h0);
    clear_inputs();

    // dcache write len=1 with wready 1,0,1; then a tie must go to port 0.
    arb_round(1'b0, 1'b1, 1'b1, 8'd1, 2, 1'b0, 1'b0, -1, 32'h0);
    clear_inputs();
    arb_round(1'b1, 1'b1, 1'b0, 8'd1, 2, 1'b0, 1'b1, -1, 32'h0);
    clear_inputs();

    // Withdrawn request leaves priority at port 0.
    arb_round(1'b0, 1'b1, 1'b0, 8'd0, 1, 1'b0, 1'b1, -1, 32'h0);
    req_drop(1'b0);
    arb_round(1'b1, 1'b1, 1'b0, 8'd0, 1, 1'b0, 1'b1, -1, 32'h0);
    clear_inputs();

    // Early rlast sets the sticky error; a clean burst afterwards still completes.
    arb_round(1'b1, 1'b0, 1'b0, 8'd3, 2, 1'b0, 1'b1, -1, 32'h0);
    tick();
    check("len_err_sticky", len_err_o, 1);
    arb_round(1'b0, 1'b1, 1'b1, 8'd2, 3, 1'b0, 1'b1, -1, 32'h0);

    // Reset in the middle of a dcache read, then a normal dcache grant.
    clear_inputs();
    arb_round(1'b0, 1'b1, 1'b0, 8'd3, 4, 1'b0, 1'b1, 2, 32'h0);
    arb_round(1'b0, 1'b1, 1'b0, 8'd1, 2, 1'b0, 1'b1, -1, 32'h0);

    // Randomized traffic against the model.
    for (int r = 0; r < 30; r++) begin
      bit          rv0, rv1, rwe;
      logic [7:0]  rlen;
      int          nb;
      clear_inputs();
      rv0  = 1'($urandom);
      rv1  = 1'($urandom);
      if (!rv0 && !rv1) rv1 = 1'b1;
      rwe  = 1'($urandom);
      rlen = 8'($urandom_range(0, 5));
      nb   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : int'(rlen) + 1;
      arb_round(rv0, rv1, rwe, rlen, nb, 1'b0, 1'b1, -1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single cache refill/writeback bus between two requesters: port 0 is the instruction cache and port 1 is the data cache.
- Sits between both caches' bus request/response interfaces and the memory-side bus.
- Grants one whole transaction at a time, using round-robin priority.
- Routes each data beat to or from the owner, and flags any burst-length mismatch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data beat width.
- LEN_W, 8, burst length field width; len = beats-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m{i}_req_valid  in  1  requester i transaction request (i=0 icache, i=1 dcache).
- m{i}_req_ready  out  1  request accepted.
- m{i}_we  in  1  1 = write burst, 0 = read burst.
- m{i}_addr  in  ADDR_W  burst start address.
- m{i}_len  in  LEN_W  beats-1.
- m{i}_wvalid / m{i}_wdata / m{i}_wstrb / m{i}_wlast  in  1/DATA_W/DATA_W/8/1  write beat.
- m{i}_wready  out  1  write beat accepted.
- m{i}_rvalid / m{i}_rdata / m{i}_rlast  out  1/DATA_W/1  read beat.
- s_req_valid / s_we / s_addr / s_len  out  1/1/ADDR_W/LEN_W  downstream request.
- s_req_ready  in  1  downstream request accepted.
- s_wvalid / s_wdata / s_wstrb / s_wlast  out  downstream write beat.
- s_wready  in  1  downstream write accepted.
- s_rvalid / s_rdata / s_rlast  in  downstream read beat.
- owner_o  out  1  current grant index, valid when busy_o=1.
- busy_o  out  1  arbiter not in IDLE.
- len_err_o  out  1  sticky: last-flag and beat count disagree.

Behaviour:
- FSM states: IDLE, REQ, RDATA, WDATA. The state register, owner, priority pointer, beat counter and latched len are all registered.
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE, owner=0, prio=0 (port 0 preferred), beat count=0, len_err_o=0.
  - All outputs are 0 and all readies are 0.
  - A burst in flight is abandoned; no beats are forwarded after reset asserts.
- IDLE:
  - With only one m{i}_req_valid asserted, grant it.
  - With both asserted, grant port prio.
  - On a grant: owner←i, go to REQ next cycle. No combinational grant path.
  - No requests: stay in IDLE.
- REQ:
  - s_req_valid = m{owner}_req_valid; s_we/s_addr/s_len come from the owner.
  - m{owner}_req_ready = s_req_ready.
  - On handshake: latch len, beat count←0, go to RDATA if we=0, else WDATA.
  - If the owner drops req_valid before the handshake (protocol violation), return to IDLE with no priority update.
- RDATA:
  - s_rvalid/s_rdata/s_rlast are routed to owner only; the non-owner's rvalid is 0.
  - Each s_rvalid increments the beat count.
  - On s_rvalid&s_rlast: go to IDLE, prio←~owner.
- WDATA:
  - Owner's w channel routed to s_w*; m{owner}_wready = s_wready; the non-owner's wready is 0.
  - Count beats on wvalid&wready.
  - On the handshake with wlast: go to IDLE, prio←~owner.
- Length check:
  - At a last beat, the count must equal the latched len; a last beat arriving early sets len_err_o.
  - A beat without last when count == len also sets len_err_o.
  - Once set, len_err_o holds until rst; the FSM still completes on the last flag.
  - The beat counter saturates at all-ones.
- Non-owner behaviour: req_ready, wready and rvalid are all 0 while the other port owns the bus. Its request stays pending.
- Latency:
  - A request asserted in cycle N (IDLE) appears on s_req_valid in cycle N+1.
  - The first new grant after completion is possible in the cycle following the last beat (one IDLE bubble minimum).
- Simultaneous events: a request raised in the same cycle as the last beat waits for IDLE and is then arbitrated with the updated prio.
- Outputs: busy_o = (state≠IDLE); owner_o = owner.

Test Plan:
- Single read: m0 read, addr=0x1C000000, len=3, s_req_ready=1, 4 s_rvalid beats with rlast on the 4th -> s_req_valid in the cycle after m0_req_valid, 4 beats delivered to m0 only, m1_rvalid=0, busy_o drops after the last beat, len_err_o=0.
- Contention: m0 and m1 both request in the same cycle after reset -> m0 granted first, then m1; repeat with both held high -> grants alternate 0,1,0,1.
- Write burst: m1 write len=1, s_wready toggling 1,0,1 -> exactly 2 beats pass with matching wdata/wstrb, completion on the wlast handshake, prio→0.
- Length error: read len=3 with rlast on beat 2 -> len_err_o=1 from the next cycle and held; FSM returns to IDLE; a subsequent good burst completes normally with len_err_o still 1.
- Reset mid-burst: assert rst in RDATA after 2 of 4 beats -> same cycle all outputs 0, busy_o=0, owner_o=0; after release, an m1 request is granted normally.
- Request drop: m0 deasserts req_valid in REQ while s_req_ready=0 -> returns to IDLE, prio unchanged, s_req_valid=0.
